soc_trace_monitor: RTL and testbench
====================================

# soc_trace_monitor

Parametrised run monitor that sits beside the `risc_v_soc` core and observes its register-file write-back port and PC. It keeps shadow copies of a configurable set of architectural registers and logs each watched write, with a cycle stamp, into a trace FIFO. It detects program halt (a PC self-loop) or a cycle timeout, then compares the shadows against expected values and reports pass/fail. It replaces per-cycle printing of fixed registers with a checkable, synthesisable block usable by benches and on-chip debug.

## Interface
Parameters:
- `NUM_WATCH`, 3: number of watched registers (1–8).
- `WATCH_LIST`, {5'd29,5'd28,5'd27}: register index of entry i at bits [5i+4:5i].
- `EXPECT_LIST`, 0: expected value of entry i at bits [32i+31:32i].
- `EXPECT_MASK`, all ones: bit i=1 means entry i takes part in the pass check.
- `FIFO_DEPTH`, 16: trace entries; power of two, at least 2.
- `HALT_CYCLES`, 4: consecutive unchanged-PC cycles that count as halt.
- `TIMEOUT_CYCLES`, 50: run-length limit in cycles.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wb_en` in 1: core register-file write enable.
- `wb_rd` in 5: write-back destination index.
- `wb_data` in 32: write-back data.
- `pc` in 32: current fetch PC.
- `trace_valid` out 1: trace FIFO non-empty.
- `trace_ready` in 1: consumer pops the head entry.
- `trace_cycle` out 32: cycle stamp of the head entry.
- `trace_rd` out 5: register index of the head entry.
- `trace_data` out 32: data of the head entry.
- `watch_values` out NUM_WATCH*32: shadow registers, entry i at [32i+31:32i].
- `done` out 1: run finished (sticky).
- `pass` out 1: all masked shadows equal their expected values; valid only when `done`=1.
- `timeout` out 1: run ended by timeout (sticky).
- `overflow` out 1: at least one trace entry was dropped (sticky).

## Operation
- FSM states: RUN → CHECK → DONE. Reset enters RUN.
- Reset clears all outputs to 0, empties the FIFO, sets `cycle_cnt` to 0 and `halt_cnt` to 0, and sets `pc_q` to 0xFFFF_FFFF. Reset asserted mid-run aborts the run; no state survives.
- RUN:
  - `cycle_cnt` increments every cycle.
  - `pc_q` <= `pc`. `halt_cnt` increments when `pc`==`pc_q`, otherwise clears to 0.
- Capture (RUN only), when `wb_en`=1 and `wb_rd`≠0:
  - Every watch entry whose index equals `wb_rd` loads `wb_data`. Duplicate list entries all update.
  - If at least one entry matches, push {`cycle_cnt`, `wb_rd`, `wb_data`}.
  - Writes to x0 and unwatched writes are ignored entirely.
- FIFO behaviour:
  - A push when full, with no pop in the same cycle, is dropped and sets `overflow`.
  - A push and a pop on a full FIFO in the same cycle are both accepted.
  - A pop when empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - Popping continues in every state.
- Halt: when `halt_cnt` reaches HALT_CYCLES-1 and `pc`==`pc_q`, the FSM moves to CHECK.
- Timeout: when `cycle_cnt` reaches TIMEOUT_CYCLES-1, the FSM moves to DONE with `timeout`=1 and `pass`=0.
- If halt and timeout occur in the same cycle, halt wins.
- CHECK lasts one cycle. It computes `pass` as the AND over i of (!EXPECT_MASK[i] | shadow[i]==EXPECT[i]), then moves to DONE.
- DONE: `done`=1. No captures occur; the counters freeze. The FSM leaves DONE only on reset.

## Timing
- A shadow update is visible on `watch_values` in the cycle after the `wb_en` edge.
- The trace head is registered: `trace_valid` rises one cycle after the push into an empty FIFO.
- A write-back in the last RUN cycle is included in the CHECK compare.
- Halt reaction: `done` rises 2 cycles after the qualifying edge (1 cycle into CHECK, 1 into DONE).
- Timeout reaction: `done` rises 1 cycle after the qualifying edge.
- The cycle stamp equals `cycle_cnt` in the capture cycle. The first cycle after reset is stamp 0.

## Structure
- Package `soc_trace_pkg` holds:
  - the state enum (RUN, CHECK, DONE);
  - `trace_entry_t` struct {cycle[31:0], rd[4:0], data[31:0]};
  - the `TRACE_W`=69 localparam.
- Sub-module `trace_fifo` is a parametrised synchronous FIFO (WIDTH, DEPTH), with `full`, `empty` and a registered head. It is instantiated once.

## Test plan
- Writes x27=5, x28=7, x29=12, then PC held at 0x40 for 4 cycles, with EXPECT_LIST={12,7,5} → three trace entries in order, `done`=1, `pass`=1, `timeout`=0.
- Same program with EXPECT x29=13 → `done`=1, `pass`=0. Masking entry 2 → `pass`=1.
- PC never repeats, TIMEOUT_CYCLES=50 → `done` rises on cycle 50, `timeout`=1, `pass`=0. Halt and timeout in the same cycle → `timeout`=0.
- 20 watched writes with `trace_ready`=0 and FIFO_DEPTH=16 → 16 entries retained (the first 16), `overflow`=1. Simultaneous push/pop while full → no drop.
- `wb_en` to x0 and to unwatched x5 → no trace entries, shadows unchanged. Duplicate WATCH_LIST entries {27,27} → both shadows updated.
- `reset` pulsed mid-run after 2 entries → FIFO empty, shadows 0, stamps restart at 0.

Source files
------------

// File: rtl/soc_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_trace_pkg
// Description : Shared types for the SoC trace monitor (FSM states, trace entry)
// Revision    : 1.0 - initial release
// ============================================================================
package soc_trace_pkg;

    localparam int TRACE_W = 69;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] cycle;
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Synchronous FIFO with a registered head entry
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign do_pop     = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_nxt = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
            // Head bypasses memory when the new entry becomes the oldest one.
            if (do_push && (empty || (do_pop && count == ONE_COUNT))) begin
                head <= din;
            end else if (do_pop) begin
                head <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/soc_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : soc_trace_monitor
// Description : Watches core write-back, traces watched writes, detects halt
//               or timeout and checks shadow registers against expectations
// Revision    : 1.0 - initial release
// ============================================================================
module soc_trace_monitor #(
    parameter int                        NUM_WATCH      = 3,
    parameter logic [5*NUM_WATCH-1:0]    WATCH_LIST     = {5'd29, 5'd28, 5'd27},
    parameter logic [32*NUM_WATCH-1:0]   EXPECT_LIST    = '0,
    parameter logic [NUM_WATCH-1:0]      EXPECT_MASK    = '1,
    parameter int                        FIFO_DEPTH     = 16,
    parameter int unsigned               HALT_CYCLES    = 4,
    parameter int unsigned               TIMEOUT_CYCLES = 50
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_en,
    input  logic [4:0]                wb_rd,
    input  logic [31:0]               wb_data,
    input  logic [31:0]               pc,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [31:0]               trace_cycle,
    output logic [4:0]                trace_rd,
    output logic [31:0]               trace_data,
    output logic [NUM_WATCH*32-1:0]   watch_values,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic                      overflow
);
    import soc_trace_pkg::*;

    state_t               state;
    state_t               state_nxt;
    logic [31:0]          cycle_cnt;
    logic [31:0]          halt_cnt;
    logic [31:0]          pc_q;
    logic [31:0]          shadow [NUM_WATCH];
    logic [NUM_WATCH-1:0] hit;
    logic [NUM_WATCH-1:0] match;
    logic                 capture;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic                 halt_hit;
    logic                 timeout_hit;
    trace_entry_t         push_entry;
    trace_entry_t         head_entry;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WATCH; gi++) begin : g_watch
            assign hit[gi]   = (WATCH_LIST[5*gi +: 5] == wb_rd);
            assign match[gi] = !EXPECT_MASK[gi] || (shadow[gi] == EXPECT_LIST[32*gi +: 32]);
            assign watch_values[32*gi +: 32] = shadow[gi];
        end
    endgenerate

    assign capture     = (state == ST_RUN) && wb_en && (wb_rd != 5'd0);
    assign push        = capture && (|hit);
    assign halt_hit    = (pc == pc_q) && (halt_cnt == 32'(HALT_CYCLES - 1));
    assign timeout_hit = (cycle_cnt == 32'(TIMEOUT_CYCLES - 1));
    // When full, the FIFO is non-empty, so a ready consumer always frees a slot.
    assign fifo_drop   = push && fifo_full && !trace_ready;
    assign push_entry  = '{cycle: cycle_cnt, rd: wb_rd, data: wb_data};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (halt_hit) begin
                    state_nxt = ST_CHECK;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_CHECK: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            cycle_cnt <= '0;
            halt_cnt  <= '0;
            pc_q      <= '1;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < NUM_WATCH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == ST_RUN) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                pc_q      <= pc;
                halt_cnt  <= (pc == pc_q) ? halt_cnt + 32'd1 : 32'd0;
                if (timeout_hit && !halt_hit) begin
                    timeout <= 1'b1;
                end
            end
            if (capture) begin
                for (int i = 0; i < NUM_WATCH; i++) begin
                    if (hit[i]) begin
                        shadow[i] <= wb_data;
                    end
                end
            end
            if (state == ST_CHECK) begin
                pass <= &match;
            end
            if (fifo_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (trace_ready),
        .head  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign done        = (state == ST_DONE);
    assign trace_valid = !fifo_empty;
    assign trace_cycle = head_entry.cycle;
    assign trace_rd    = head_entry.rd;
    assign trace_data  = head_entry.data;

endmodule
`default_nettype wire

// File: tb/tb_soc_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_trace_monitor
// Description : Self-checking bench for soc_trace_monitor
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_trace_monitor;
    import soc_trace_pkg::*;

    logic        clk;
    logic        reset;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] pc;
    logic        trace_ready;

    logic        trace_valid;
    logic [31:0] trace_cycle;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [95:0] watch_values;
    logic        done, pass, timeout, overflow;

    // Secondary instances: expect mismatch, masked mismatch, halt/timeout tie, duplicates
    logic        b_tv, m_tv, t_tv, d_tv;
    logic [31:0] b_tc, m_tc, t_tc, d_tc, b_td, m_td, t_td, d_td;
    logic [4:0]  b_tr, m_tr, t_tr, d_tr;
    logic [95:0] b_wv, m_wv, t_wv;
    logic [63:0] d_wv;
    logic        b_done, b_pass, b_to, b_ov;
    logic        m_done, m_pass, m_to, m_ov;
    logic        t_done, t_pass, t_to, t_ov;
    logic        d_done, d_pass, d_to, d_ov;

    int n_vec = 0;
    int n_bad = 0;
    int stamp = 0;
    trace_entry_t sb [$];

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic        push;
        logic [95:0] watch;
        logic        done;
    } vec_t;
    vec_t tbl [12];

    soc_trace_monitor #(.EXPECT_LIST({32'd12, 32'd7, 32'd5})) u_dut (
        .clk(clk), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .pc(pc),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_cycle(trace_cycle),
        .trace_rd(trace_rd), .trace_data(trace_data), .watch_values(watch_values),
        .done(done), .pass(pass), .timeout(timeout), .overflow(overflow));

    soc_trace_monitor #(.EXPECT_LIST({32'd13, 32'd7, 32'd5})) u_bad (
        .clk(clk), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .pc(pc),
        .trace_valid(b_tv), .trace_ready(trace_ready), .trace_cycle(b_tc),
        .trace_rd(b_tr), .trace_data(b_td), .watch_values(b_wv),
        .done(b_done), .pass(b_pass), .timeout(b_to), .overflow(b_ov));

    soc_trace_monitor #(.EXPECT_LIST({32'd13, 32'd7, 32'd5}), .EXPECT_MASK(3'b011)) u_msk (
        .clk(clk), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .pc(pc),
        .trace_valid(m_tv), .trace_ready(trace_ready), .trace_cycle(m_tc),
        .trace_rd(m_tr), .trace_data(m_td), .watch_values(m_wv),
        .done(m_done), .pass(m_pass), .timeout(m_to), .overflow(m_ov));

    soc_trace_monitor #(.EXPECT_LIST({32'd12, 32'd7, 32'd5}), .TIMEOUT_CYCLES(10)) u_tie (
        .clk(clk), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .pc(pc),
        .trace_valid(t_tv), .trace_ready(trace_ready), .trace_cycle(t_tc),
        .trace_rd(t_tr), .trace_data(t_td), .watch_values(t_wv),
        .done(t_done), .pass(t_pass), .timeout(t_to), .overflow(t_ov));

    soc_trace_monitor #(.NUM_WATCH(2), .WATCH_LIST({5'd27, 5'd27}),
                        .EXPECT_LIST({32'd5, 32'd5})) u_dup (
        .clk(clk), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .pc(pc),
        .trace_valid(d_tv), .trace_ready(trace_ready), .trace_cycle(d_tc),
        .trace_rd(d_tr), .trace_data(d_td), .watch_values(d_wv),
        .done(d_done), .pass(d_pass), .timeout(d_to), .overflow(d_ov));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        stamp++;
    endtask

    task automatic do_reset();
        reset = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0; pc = '0; trace_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        stamp = 0;
        sb.delete();
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        sb.push_back('{cycle: 32'(stamp), rd: rd, data: data});
    endtask

    task automatic drain(input int max_cycles);
        trace_entry_t e;
        int c;
        c = 0;
        while (sb.size() > 0 && c < max_cycles) begin
            if (trace_valid) begin
                e = sb.pop_front();
                check("trace_head", {trace_cycle, trace_rd, trace_data}, e);
                trace_ready = 1'b1;
            end
            tick();
            trace_ready = 1'b0;
            c++;
        end
        check("drain_remaining", 128'(sb.size()), 0);
        check("valid_after_drain", trace_valid, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd5,  32'd99, 32'h00, 1'b0, {32'd0,  32'd0, 32'd0}, 1'b0};
        tbl[1]  = '{1'b1, 5'd0,  32'd77, 32'h04, 1'b0, {32'd0,  32'd0, 32'd0}, 1'b0};
        tbl[2]  = '{1'b1, 5'd27, 32'd5,  32'h08, 1'b1, {32'd0,  32'd0, 32'd5}, 1'b0};
        tbl[3]  = '{1'b1, 5'd28, 32'd7,  32'h0C, 1'b1, {32'd0,  32'd7, 32'd5}, 1'b0};
        tbl[4]  = '{1'b1, 5'd29, 32'd12, 32'h10, 1'b1, {32'd12, 32'd7, 32'd5}, 1'b0};
        for (int i = 5; i < 10; i++) begin
            tbl[i] = '{1'b0, 5'd0, 32'd0, 32'h40, 1'b0, {32'd12, 32'd7, 32'd5}, 1'b0};
        end
        tbl[10] = '{1'b0, 5'd0,  32'd0,  32'h40, 1'b0, {32'd12, 32'd7, 32'd5}, 1'b1};
        tbl[11] = '{1'b1, 5'd27, 32'd55, 32'h40, 1'b0, {32'd12, 32'd7, 32'd5}, 1'b1};

        // Reset state
        do_reset();
        check("rst_valid", trace_valid, 0);
        check("rst_watch", watch_values, 0);
        check("rst_flags", {done, pass, timeout, overflow}, 0);
        check("rst_head", {trace_cycle, trace_rd, trace_data}, 0);

        // Program with halt: table-driven
        for (int i = 0; i < 12; i++) begin
            wb_en = tbl[i].en; wb_rd = tbl[i].rd; wb_data = tbl[i].data; pc = tbl[i].pc;
            if (tbl[i].push) push_exp(tbl[i].rd, tbl[i].data);
            tick();
            check($sformatf("vec_watch[%0d]", i), watch_values, tbl[i].watch);
            check($sformatf("vec_done[%0d]", i), done, tbl[i].done);
        end
        wb_en = 1'b0;
        check("halt_pass", pass, 1);
        check("halt_timeout", timeout, 0);
        check("halt_overflow", overflow, 0);
        check("bad_done_pass", {b_done, b_pass}, 2'b10);
        check("mask_done_pass", {m_done, m_pass}, 2'b11);
        check("tie_done_pass_to", {t_done, t_pass, t_to}, 3'b110);
        check("dup_watch", d_wv, {32'd5, 32'd5});
        drain(10);

        // Timeout: PC never repeats
        do_reset();
        for (int k = 0; k < 49; k++) begin
            pc = 32'h100 + 32'(4 * k);
            tick();
        end
        check("pre_timeout_done", done, 0);
        pc = 32'h100 + 32'(4 * 49);
        tick();
        check("timeout_flags", {done, pass, timeout}, 3'b101);

        // Overflow: 20 writes with no consumer
        do_reset();
        for (int k = 0; k < 20; k++) begin
            wb_en = 1'b1; wb_rd = 5'd27; wb_data = 32'd100 + 32'(k); pc = 32'h200 + 32'(4 * k);
            if (k < 16) push_exp(wb_rd, wb_data);
            tick();
        end
        check("overflow_flag", overflow, 1);
        check("overflow_valid", trace_valid, 1);
        // Push and pop together while full: nothing may be dropped
        wb_rd = 5'd28; wb_data = 32'hAA; pc = 32'h300; trace_ready = 1'b1;
        check("full_pushpop_head", {trace_cycle, trace_rd, trace_data}, sb.pop_front());
        push_exp(wb_rd, wb_data);
        tick();
        wb_en = 1'b0; trace_ready = 1'b0;
        drain(40);

        // Reset mid-run with two entries queued
        do_reset();
        wb_en = 1'b1; wb_rd = 5'd27; wb_data = 32'd1; pc = 32'h10;
        tick();
        wb_rd = 5'd28; wb_data = 32'd2; pc = 32'h14;
        tick();
        wb_en = 1'b0; pc = 32'h18;
        tick();
        check("mid_valid", trace_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; stamp = 0; sb.delete();
        check("mid_rst_valid", trace_valid, 0);
        check("mid_rst_watch", watch_values, 0);
        check("mid_rst_flags", {done, pass, timeout, overflow}, 0);
        wb_en = 1'b1; wb_rd = 5'd29; wb_data = 32'd3; pc = 32'h20;
        push_exp(wb_rd, wb_data);
        tick();
        wb_en = 1'b0; pc = 32'h24;
        drain(10);
        check("mid_watch_after", watch_values, {32'd3, 32'd0, 32'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
